// File: rtl/dc_pkg.sv
// dc_pkg -- shared definitions for the DC insertion block.
//   dc_state_t    : run-control FSM states (IDLE, RAMP, RUN, DRAIN)
//   DC_DATA_WIDTH : default DAC code width
//   dc_clamp()    : clamps a signed value into the DAC code range [0, max_code]
package dc_pkg;

    localparam int DC_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } dc_state_t;

    function automatic int dc_clamp(input int value, input int max_code);
        int result;
        result = value;
        if (value < 0) begin
            result = 0;
        end else if (value > max_code) begin
            result = max_code;
        end
        return result;
    endfunction

endpackage

// File: rtl/dc_offset_ramp.sv
// dc_offset_ramp -- slews the DC offset toward a goal in bounded steps.
// Every RAMP_DIV cycles while active, cur_offset moves toward goal by
// min(RAMP_STEP, |goal - cur_offset|).
// Ports:
//   clk        in   clock (rising edge)
//   rst        in   asynchronous active-high reset
//   clear      in   force cur_offset to zero (owner is idle)
//   active     in   stepping enabled
//   restart    in   owner changes state this cycle; tick counter restarts
//   goal       in   offset being approached
//   cur_offset out  present offset
//   reached    out  cur_offset equals goal
module dc_offset_ramp #(
    parameter int DATA_WIDTH = 12,
    parameter int RAMP_STEP  = 8,
    parameter int RAMP_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  active,
    input  logic                  restart,
    input  logic [DATA_WIDTH-1:0] goal,
    output logic [DATA_WIDTH-1:0] cur_offset,
    output logic                  reached
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAMP_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(RAMP_STEP);

    logic [CNT_W-1:0]      tick_cnt;
    logic                  tick;
    logic [DATA_WIDTH-1:0] next_offset;

    assign tick    = active && (tick_cnt == LAST_CNT);
    assign reached = (cur_offset == goal);

    // The final step is shortened so the offset lands exactly on the goal.
    always_comb begin
        next_offset = cur_offset;
        if (goal > cur_offset) begin
            if ((goal - cur_offset) > STEP_W) begin
                next_offset = cur_offset + STEP_W;
            end else begin
                next_offset = goal;
            end
        end else if (goal < cur_offset) begin
            if ((cur_offset - goal) > STEP_W) begin
                next_offset = cur_offset - STEP_W;
            end else begin
                next_offset = goal;
            end
        end
    end

    // A tick falling on a state-change edge still steps; only the count restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (restart || !active || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_offset <= '0;
        end else if (clear) begin
            cur_offset <= '0;
        end else if (tick) begin
            cur_offset <= next_offset;
        end
    end

endmodule

// File: rtl/dc_insertion.sv
// dc_insertion -- adds a slewed DC offset to an AC sample stream for a DAC.
// Build option: define DC_INSERTION_SAT_CNT_EN to add the sat_count output.
// Ports:
//   dac_clk     in   sole clock
//   rst         in   asynchronous active-high reset
//   stable      in   run request (1 = ramp up and run, 0 = ramp down and idle)
//   data_in     in   signed AC sample, DATA_WIDTH+1 bits
//   en          in   data_in valid strobe
//   offset_in   in   unsigned target DC offset
//   offset_load in   pulse latching offset_in as the target
//   data_out    out  unsigned DAC code
//   valid_out   out  data_out updated this cycle
//   sat         out  current data_out was clamped
//   ramp_busy   out  offset is slewing (RAMP or DRAIN)
//   sat_count   out  saturated-sample count (only with DC_INSERTION_SAT_CNT_EN)
module dc_insertion
    import dc_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int RAMP_STEP  = 8,
    parameter int RAMP_DIV   = 4
) (
    input  logic                  dac_clk,
    input  logic                  rst,
    input  logic                  stable,
    input  logic [DATA_WIDTH:0]   data_in,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] offset_in,
    input  logic                  offset_load,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  sat,
    output logic                  ramp_busy
`ifdef DC_INSERTION_SAT_CNT_EN
    ,
    output logic [15:0]           sat_count
`endif
);

    localparam int MAX_CODE = (1 << DATA_WIDTH) - 1;

    dc_state_t                    state;
    dc_state_t                    state_next;
    logic [DATA_WIDTH-1:0]        target;
    logic [DATA_WIDTH-1:0]        goal;
    logic [DATA_WIDTH-1:0]        cur_offset;
    logic                         reached;
    logic                         retarget;
    logic signed [DATA_WIDTH+1:0] sum;
    int                           clamped;
    logic                         clamp_hit;

    // DRAIN always heads for zero; the latched target is kept for a later RAMP.
    assign goal      = (state == DRAIN) ? '0 : target;
    assign ramp_busy = (state == RAMP) || (state == DRAIN);
    assign retarget  = offset_load && (offset_in != cur_offset);

    dc_offset_ramp #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV)
    ) u_ramp (
        .clk       (dac_clk),
        .rst       (rst),
        .clear     (state == IDLE),
        .active    (ramp_busy),
        .restart   (state_next != state),
        .goal      (goal),
        .cur_offset(cur_offset),
        .reached   (reached)
    );

    always_ff @(posedge dac_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RAMP does not settle into RUN if a new, different target arrives in the
    // same cycle it reaches the old one.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (stable) state_next = RAMP;
            end
            RAMP: begin
                if (!stable) state_next = DRAIN;
                else if (reached && !retarget) state_next = RUN;
            end
            RUN: begin
                if (!stable) state_next = DRAIN;
                else if (retarget) state_next = RAMP;
            end
            DRAIN: begin
                if (stable) state_next = RAMP;
                else if (reached) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge dac_clk or posedge rst) begin
        if (rst) begin
            target <= '0;
        end else if (offset_load) begin
            target <= offset_in;
        end
    end

    // Two extra bits keep the signed sum free of overflow before clamping.
    assign sum       = $signed({data_in[DATA_WIDTH], data_in}) + $signed({2'b00, cur_offset});
    assign clamped   = dc_clamp(int'(sum), MAX_CODE);
    assign clamp_hit = (clamped != int'(sum));

    // Output register: forced to zero in IDLE, otherwise loads on en and holds.
    always_ff @(posedge dac_clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            sat       <= 1'b0;
        end else if (state == IDLE) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            sat       <= 1'b0;
        end else if (en) begin
            data_out  <= DATA_WIDTH'(clamped);
            valid_out <= 1'b1;
            sat       <= clamp_hit;
        end else begin
            valid_out <= 1'b0;
            sat       <= 1'b0;
        end
    end

`ifdef DC_INSERTION_SAT_CNT_EN
    // Counts clamped output samples; a fresh start from IDLE clears it.
    always_ff @(posedge dac_clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if ((state == IDLE) && (state_next == RAMP)) begin
            sat_count <= '0;
        end else if ((state != IDLE) && en && clamp_hit && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dc_insertion.sv
// tb_dc_insertion -- self-checking bench for dc_insertion.
// A behavioural model of the offset slew and output arithmetic runs alongside
// the DUT; every cycle's outputs are compared, plus directed value checks.
module tb_dc_insertion;

    localparam int W     = 12;
    localparam int STEP  = 8;
    localparam int DIV   = 4;
    localparam int MAXC  = (1 << W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_RAMP  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;

    logic                dac_clk = 1'b0;
    logic                rst;
    logic                stable;
    logic signed [W:0]   data_in;
    logic                en;
    logic [W-1:0]        offset_in;
    logic                offset_load;
    logic [W-1:0]        data_out;
    logic                valid_out;
    logic                sat;
    logic                ramp_busy;
`ifdef DC_INSERTION_SAT_CNT_EN
    logic [15:0]         sat_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    int m_phase, m_off, m_tgt, m_age, m_dout, m_valid, m_sat, m_satcnt;

    dc_insertion #(
        .DATA_WIDTH(W),
        .RAMP_STEP (STEP),
        .RAMP_DIV  (DIV)
    ) dut (
        .dac_clk    (dac_clk),
        .rst        (rst),
        .stable     (stable),
        .data_in    (data_in),
        .en         (en),
        .offset_in  (offset_in),
        .offset_load(offset_load),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .sat        (sat),
        .ramp_busy  (ramp_busy)
`ifdef DC_INSERTION_SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 dac_clk = ~dac_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_phase  = P_IDLE;
        m_off    = 0;
        m_tgt    = 0;
        m_age    = 0;
        m_dout   = 0;
        m_valid  = 0;
        m_sat    = 0;
        m_satcnt = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at it.
    task automatic modelEdge();
        int s, goal, diff, mv, new_off, new_phase;
        if (m_phase == P_IDLE) begin
            m_dout = 0; m_valid = 0; m_sat = 0;
        end else if (en) begin
            s       = int'(data_in) + m_off;
            m_sat   = (s < 0 || s > MAXC) ? 1 : 0;
            m_dout  = (s < 0) ? 0 : ((s > MAXC) ? MAXC : s);
            m_valid = 1;
        end else begin
            m_valid = 0; m_sat = 0;
        end
        new_off = m_off;
        if ((m_phase == P_RAMP || m_phase == P_DRAIN) && (m_age % DIV == DIV - 1)) begin
            goal    = (m_phase == P_RAMP) ? m_tgt : 0;
            diff    = goal - m_off;
            mv      = (diff < 0) ? -diff : diff;
            if (mv > STEP) mv = STEP;
            new_off = (diff > 0) ? m_off + mv : m_off - mv;
        end
        new_phase = m_phase;
        case (m_phase)
            P_IDLE:  if (stable) new_phase = P_RAMP;
            P_RAMP:  if (!stable) new_phase = P_DRAIN;
                     else if (m_off == m_tgt && !(offset_load && int'(offset_in) != m_off)) new_phase = P_RUN;
            P_RUN:   if (!stable) new_phase = P_DRAIN;
                     else if (offset_load && int'(offset_in) != m_off) new_phase = P_RAMP;
            default: if (stable) new_phase = P_RAMP;
                     else if (m_off == 0) new_phase = P_IDLE;
        endcase
        if (m_phase == P_IDLE && new_phase == P_RAMP) m_satcnt = 0;
        else if (m_valid == 1 && m_sat == 1 && m_satcnt < 65535) m_satcnt++;
        if (offset_load) m_tgt = int'(offset_in);
        m_age   = (new_phase != m_phase) ? 0 : m_age + 1;
        m_off   = new_off;
        m_phase = new_phase;
    endtask

    task automatic checkAll();
        checkOutput("data_out", 32'(data_out), m_dout);
        checkOutput("valid_out", 32'(valid_out), m_valid);
        checkOutput("sat", 32'(sat), m_sat);
        checkOutput("ramp_busy", 32'(ramp_busy), (m_phase == P_RAMP || m_phase == P_DRAIN) ? 1 : 0);
`ifdef DC_INSERTION_SAT_CNT_EN
        checkOutput("sat_count", 32'(sat_count), m_satcnt);
`endif
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge dac_clk);
            modelEdge();
            #1;
            checkAll();
        end
    endtask

    // en_mode: 0 = no samples, 1 = zero samples every cycle, 2 = random in-range samples.
    task automatic runUntil(input int phase, input int bound, input int en_mode, output int busy);
        int n;
        n    = 0;
        busy = 0;
        while (m_phase != phase && n < bound) begin
            case (en_mode)
                1: begin en = 1'b1; data_in = '0; end
                2: begin en = ($urandom_range(2) == 0); data_in = (W+1)'($urandom_range(2000)); end
                default: en = 1'b0;
            endcase
            applyStimulus(1);
            if (ramp_busy) busy++;
            n++;
        end
        en = 1'b0;
        if (m_phase != phase) checkOutput("phase_timeout", m_phase, phase);
    endtask

    task automatic loadOffset(input int value);
        offset_in   = W'(value);
        offset_load = 1'b1;
        applyStimulus(1);
        offset_load = 1'b0;
    endtask

    task automatic sample(input int value);
        en      = 1'b1;
        data_in = (W+1)'(value);
        applyStimulus(1);
        en      = 1'b0;
    endtask

    initial begin
        int busy;
        rst = 1'b1; stable = 1'b0; en = 1'b0; data_in = '0;
        offset_in = '0; offset_load = 1'b0;
        modelReset();
        #2;
        checkAll();
        repeat (2) @(posedge dac_clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");

        // Ramp from zero to 1500 with random in-range samples.
        offset_in = W'(1500); offset_load = 1'b1; stable = 1'b1;
        applyStimulus(1);
        offset_load = 1'b0;
        runUntil(P_RUN, 2000, 2, busy);
        checkOutput("ramp_up_cycles", busy + 1, 1 + DIV * ((1500 + STEP - 1) / STEP));
        checkOutput("ramp_busy_run", 32'(ramp_busy), 0);

        // Offset arithmetic in RUN.
        sample(500);
        checkOutput("run_plus500", 32'(data_out), 2000);
        checkOutput("run_plus500_valid", 32'(valid_out), 1);
        checkOutput("run_plus500_sat", 32'(sat), 0);
        sample(-500);
        checkOutput("run_minus500", 32'(data_out), 1000);
        applyStimulus(1);
        checkOutput("hold_value", 32'(data_out), 1000);
        checkOutput("hold_valid", 32'(valid_out), 0);

        // Clamping at both ends.
        loadOffset(4000);
        runUntil(P_RUN, 3000, 0, busy);
        sample(500);
        checkOutput("clamp_high", 32'(data_out), MAXC);
        checkOutput("clamp_high_sat", 32'(sat), 1);
        loadOffset(100);
        runUntil(P_RUN, 3000, 0, busy);
        sample(-500);
        checkOutput("clamp_low", 32'(data_out), 0);
        checkOutput("clamp_low_sat", 32'(sat), 1);
        applyStimulus(1);
`ifdef DC_INSERTION_SAT_CNT_EN
        checkOutput("sat_count_two", 32'(sat_count), 2);
`endif

        // Drain from 1500 down to idle; samples are ignored afterwards.
        loadOffset(1500);
        runUntil(P_RUN, 2000, 0, busy);
        stable = 1'b0;
        runUntil(P_IDLE, 2000, 0, busy);
        checkOutput("drain_cycles", busy, 1 + DIV * ((1500 + STEP - 1) / STEP));
        sample(700);
        sample(700);
        checkOutput("idle_dout", 32'(data_out), 0);
        checkOutput("idle_valid", 32'(valid_out), 0);

        // Brief drop of stable mid-ramp, then resume without a jump.
        stable = 1'b1;
        applyStimulus(1);
        for (int i = 0; i < 1000 && m_off != 800; i++) applyStimulus(1);
        checkOutput("mid_ramp_reached", m_off, 800);
        stable = 1'b0;
        applyStimulus(40);
        stable = 1'b1;
        applyStimulus(1);
        sample(0);
        checkOutput("resume_offset", 32'(data_out), 720);
        runUntil(P_RUN, 2000, 1, busy);
        sample(0);
        checkOutput("resume_final", 32'(data_out), 1500);

        // Random run requests, retargets and full-range samples.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(149) == 0) stable = ~stable;
            offset_load = ($urandom_range(99) == 0);
            offset_in   = W'($urandom_range(MAXC));
            en          = ($urandom_range(1) == 0);
            data_in     = (W+1)'(int'($urandom_range(8191)) - 4096);
            applyStimulus(1);
        end
        offset_load = 1'b0; en = 1'b0;

        // Reset in the middle of a ramp discards the pending target.
        @(posedge dac_clk);
        rst = 1'b1; modelReset();
        @(posedge dac_clk);
        #1;
        rst = 1'b0; stable = 1'b1;
        loadOffset(1000);
        applyStimulus(100);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst_dout", 32'(data_out), 0);
        checkOutput("async_rst_busy", 32'(ramp_busy), 0);
        checkAll();
        @(posedge dac_clk);
        #1;
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("post_rst_run_busy", 32'(ramp_busy), 0);
        sample(300);
        checkOutput("post_rst_offset_zero", 32'(data_out), 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
